// File: rtl/ptp_rtc_ctrl_if.sv
// rtl/ptp_rtc_ctrl_if.sv - command request bus into the PTP RTC controller
interface ptp_rtc_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_type_i;
  logic [47:0] req_sc_i;
  logic [31:0] req_ns_i;
  logic [31:0] req_tick_i;
  logic [23:0] req_cyc_i;

  modport master (
    output req_valid_i, req_type_i, req_sc_i, req_ns_i, req_tick_i, req_cyc_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i, req_type_i, req_sc_i, req_ns_i, req_tick_i, req_cyc_i,
    output req_ready_o
  );
endinterface

// File: rtl/ptp_rtc_ctrl.sv
// rtl/ptp_rtc_ctrl.sv - sequences STEP/SLEW/SETFREQ/CLEAR commands onto the RTC control signals
module ptp_rtc_ctrl #(
  parameter logic [31:0] TICK_DEF  = 32'h1999_999A,
  parameter int          GUARD_CYC = 8,
  parameter int          CLR_CYC   = 4
) (
  input  logic          rtc_clk,
  input  logic          rtc_rst_n,
  ptp_rtc_ctrl_if.slave req,
  output logic [31:0]   tick_inc_o,
  output logic [31:0]   ns_offset_o,
  output logic [47:0]   sc_offset_o,
  output logic          offset_valid_o,
  output logic          clear_rtc_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_GUARD, S_SLEW, S_CLR} state_t;

  localparam logic [1:0] T_STEP    = 2'd0;
  localparam logic [1:0] T_SLEW    = 2'd1;
  localparam logic [1:0] T_SETFREQ = 2'd2;
  localparam logic [1:0] T_CLEAR   = 2'd3;
  localparam int signed  NS_LIMIT  = 1_000_000_000;

  state_t      state, state_nxt;
  logic [31:0] base_tick;
  logic [31:0] slew_tick;
  logic [23:0] cnt;
  logic        done_r;
  logic        err_r;

  logic        accept;
  logic        step_ok;
  logic        slew_ok;
  logic [33:0] slew_sum;

  assign accept  = req.req_valid_i && (state == S_IDLE);
  assign step_ok = ($signed(req.req_ns_i) < NS_LIMIT) && ($signed(req.req_ns_i) > -NS_LIMIT);
  // Extra headroom bit so both underflow (bit 33) and >= 2^32 (bit 32) are visible.
  assign slew_sum = {2'b00, base_tick} + {{2{req.req_ns_i[31]}}, req.req_ns_i};
  assign slew_ok  = !slew_sum[33] && !slew_sum[32] && (slew_sum[31:0] != 32'd0);

  always_ff @(posedge rtc_clk) begin
    if (!rtc_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (req.req_type_i)
            T_STEP:  if (step_ok) state_nxt = S_STEP;
            T_SLEW:  if (slew_ok && (req.req_cyc_i != 24'd0)) state_nxt = S_SLEW;
            T_CLEAR: state_nxt = S_CLR;
            default: state_nxt = S_IDLE;
          endcase
        end
      end
      S_STEP:  state_nxt = S_GUARD;
      S_GUARD: if (cnt == 24'd0) state_nxt = S_IDLE;
      S_SLEW:  if (cnt == 24'd0) state_nxt = S_IDLE;
      S_CLR:   if (cnt == 24'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rtc_clk) begin
    if (!rtc_rst_n) begin
      base_tick   <= TICK_DEF;
      slew_tick   <= 32'd0;
      cnt         <= 24'd0;
      ns_offset_o <= 32'd0;
      sc_offset_o <= 48'd0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (cnt != 24'd0) cnt <= cnt - 24'd1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (req.req_type_i)
              T_STEP: begin
                if (step_ok) begin
                  ns_offset_o <= req.req_ns_i;
                  sc_offset_o <= req.req_sc_i;
                end else begin
                  err_r <= 1'b1;
                end
              end
              T_SLEW: begin
                if (!slew_ok) begin
                  err_r <= 1'b1;
                end else if (req.req_cyc_i == 24'd0) begin
                  done_r <= 1'b1;
                end else begin
                  slew_tick <= slew_sum[31:0];
                  cnt       <= req.req_cyc_i - 24'd1;
                end
              end
              T_SETFREQ: begin
                if (req.req_tick_i != 32'd0) begin
                  base_tick <= req.req_tick_i;
                  done_r    <= 1'b1;
                end else begin
                  err_r <= 1'b1;
                end
              end
              default: cnt <= 24'(CLR_CYC - 1);
            endcase
          end
        end
        S_STEP: cnt <= 24'(GUARD_CYC - 1);
        // SLEW and CLR report completion in the cycle after their last active cycle.
        S_SLEW: if (cnt == 24'd0) done_r <= 1'b1;
        S_CLR:  if (cnt == 24'd0) done_r <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    req.req_ready_o = (state == S_IDLE);
    busy_o          = (state != S_IDLE);
    offset_valid_o  = (state == S_STEP);
    clear_rtc_o     = (state == S_CLR);
    tick_inc_o      = (state == S_SLEW) ? slew_tick : base_tick;
    done_o          = done_r || ((state == S_GUARD) && (cnt == 24'd0));
    err_o           = err_r;
  end

endmodule

// File: tb/tb_ptp_rtc_ctrl.sv
// tb/tb_ptp_rtc_ctrl.sv - directed self-checking bench for ptp_rtc_ctrl
module tb_ptp_rtc_ctrl;
  localparam logic [31:0] TICK_DEF = 32'h1999_999A;

  logic        clk;
  logic        rst_n;
  logic [31:0] tick_inc;
  logic [31:0] ns_offset;
  logic [47:0] sc_offset;
  logic        offset_valid;
  logic        clear_rtc;
  logic        busy;
  logic        done;
  logic        err;
  int          checks;
  int          errors;

  ptp_rtc_ctrl_if bus ();

  ptp_rtc_ctrl dut (
    .rtc_clk        (clk),
    .rtc_rst_n      (rst_n),
    .req            (bus),
    .tick_inc_o     (tick_inc),
    .ns_offset_o    (ns_offset),
    .sc_offset_o    (sc_offset),
    .offset_valid_o (offset_valid),
    .clear_rtc_o    (clear_rtc),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [1:0] t, input logic [47:0] sc, input logic [31:0] ns,
                      input logic [31:0] tk, input logic [23:0] cyc);
    @(posedge clk);
    #1;
    bus.req_type_i  = t;
    bus.req_sc_i    = sc;
    bus.req_ns_i    = ns;
    bus.req_tick_i  = tk;
    bus.req_cyc_i   = cyc;
    bus.req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_type_i  = 2'd0;
    bus.req_sc_i    = 48'd0;
    bus.req_ns_i    = 32'd0;
    bus.req_tick_i  = 32'd0;
    bus.req_cyc_i   = 24'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tick_inc !== TICK_DEF) begin errors++; $display("FAIL reset_tick: got %h exp %h", tick_inc, TICK_DEF); end
    checks++;
    if ({ns_offset, sc_offset} !== 80'd0) begin errors++; $display("FAIL reset_offsets: got %h/%h exp 0", ns_offset, sc_offset); end
    checks++;
    if ({offset_valid, clear_rtc, done, err, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b exp 00000", {offset_valid, clear_rtc, done, err, busy});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", bus.req_ready_o); end
    checks++;
    if (tick_inc !== 32'h1999_999A) begin errors++; $display("FAIL idle_tick: got %h exp 1999999a", tick_inc); end
  endtask

  task automatic test_step;
    int busy_n = 0, ov_n = 0, ov_k = 0, done_n = 0, done_k = 0, err_n = 0;
    logic [47:0] sc_seen = '0;
    logic [31:0] ns_seen = '0;
    send(2'd0, 48'hFFFF_FFFF_FFFF, 32'd500_000_000, 32'd0, 24'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (offset_valid) begin ov_n++; ov_k = k; sc_seen = sc_offset; ns_seen = ns_offset; end
      if (done) begin done_n++; done_k = k; end
      if (err) err_n++;
    end
    checks++;
    if (ov_n !== 1 || ov_k !== 1) begin errors++; $display("FAIL step_offset_pulse: got n=%0d k=%0d exp n=1 k=1", ov_n, ov_k); end
    checks++;
    if (sc_seen !== 48'hFFFF_FFFF_FFFF || ns_seen !== 32'd500_000_000) begin
      errors++; $display("FAIL step_offset_vals: got %h/%0d exp ffffffffffff/500000000", sc_seen, ns_seen);
    end
    checks++;
    if (busy_n !== 9) begin errors++; $display("FAIL step_busy_cycles: got %0d exp 9", busy_n); end
    checks++;
    if (done_n !== 1 || done_k !== 9 || err_n !== 0) begin
      errors++; $display("FAIL step_done: got n=%0d k=%0d err=%0d exp n=1 k=9 err=0", done_n, done_k, err_n);
    end
    checks++;
    if (ns_offset !== 32'd500_000_000) begin errors++; $display("FAIL step_ns_hold: got %0d exp 500000000", ns_offset); end
  endtask

  task automatic test_step_err;
    int ov_n = 0, err_n = 0, err_k = 0, done_n = 0, busy_n = 0;
    logic [31:0] ns_list [2];
    logic [31:0] ns_neg;
    ns_list[0] = 32'd1_000_000_000;
    ns_list[1] = 32'h8000_0000;
    for (int i = 0; i < 2; i++) begin
      ov_n = 0; err_n = 0; err_k = 0; done_n = 0; busy_n = 0;
      send(2'd0, 48'd7, ns_list[i], 32'd0, 24'd0);
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (offset_valid) ov_n++;
        if (err) begin err_n++; err_k = k; end
        if (done) done_n++;
        if (busy) busy_n++;
      end
      checks++;
      if (err_n !== 1 || err_k !== 1 || ov_n !== 0 || done_n !== 0 || busy_n !== 0) begin
        errors++;
        $display("FAIL step_reject[%0d]: got err=%0d@%0d ov=%0d done=%0d busy=%0d exp err=1@1 ov=0 done=0 busy=0",
                 i, err_n, err_k, ov_n, done_n, busy_n);
      end
    end
    checks++;
    if (ns_offset !== 32'd500_000_000) begin errors++; $display("FAIL step_reject_hold: got %0d exp 500000000", ns_offset); end
    ns_neg = 32'(-999_999_999);
    ov_n = 0; done_n = 0; err_n = 0;
    send(2'd0, 48'd5, ns_neg, 32'd0, 24'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (offset_valid) begin
        ov_n++;
        checks++;
        if (ns_offset !== 32'hC465_3601 || sc_offset !== 48'd5) begin
          errors++; $display("FAIL step_after_err_vals: got %h/%0d exp c4653601/5", ns_offset, sc_offset);
        end
      end
      if (done) done_n++;
      if (err) err_n++;
    end
    checks++;
    if (ov_n !== 1 || done_n !== 1 || err_n !== 0) begin
      errors++; $display("FAIL step_after_err: got ov=%0d done=%0d err=%0d exp 1/1/0", ov_n, done_n, err_n);
    end
  endtask

  task automatic test_setfreq_slew;
    logic [31:0] exp_tick;
    send(2'd2, 48'd0, 32'd0, 32'h1900_0000, 24'd0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || tick_inc !== 32'h1900_0000 || busy !== 1'b0) begin
      errors++; $display("FAIL setfreq: got done=%b tick=%h busy=%b exp 1/19000000/0", done, tick_inc, busy);
    end
    send(2'd1, 48'd0, 32'd256, 32'd0, 24'd3);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_tick = (k <= 3) ? 32'h1900_0100 : 32'h1900_0000;
      checks++;
      if (tick_inc !== exp_tick || done !== (k == 4) || err !== 1'b0) begin
        errors++; $display("FAIL slew_cycle[%0d]: got tick=%h done=%b err=%b exp %h/%b/0", k, tick_inc, done, err, exp_tick, k == 4);
      end
    end
    send(2'd2, 48'd0, 32'd0, 32'd0, 24'd0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || tick_inc !== 32'h1900_0000) begin
      errors++; $display("FAIL setfreq_zero: got err=%b done=%b tick=%h exp 1/0/19000000", err, done, tick_inc);
    end
    send(2'd1, 48'd0, 32'hE700_0000, 32'd0, 24'd5);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || tick_inc !== 32'h1900_0000) begin
      errors++; $display("FAIL slew_to_zero: got err=%b busy=%b tick=%h exp 1/0/19000000", err, busy, tick_inc);
    end
    send(2'd1, 48'd0, 32'd64, 32'd0, 24'd0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || tick_inc !== 32'h1900_0000) begin
      errors++; $display("FAIL slew_cyc0: got done=%b err=%b busy=%b tick=%h exp 1/0/0/19000000", done, err, busy, tick_inc);
    end
    send(2'd2, 48'd0, 32'd0, 32'hF000_0000, 24'd0);
    send(2'd1, 48'd0, 32'h1000_0000, 32'd0, 24'd5);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || tick_inc !== 32'hF000_0000) begin
      errors++; $display("FAIL slew_overflow: got err=%b busy=%b tick=%h exp 1/0/f0000000", err, busy, tick_inc);
    end
  endtask

  task automatic test_back_to_back;
    int clr_n = 0, bad_ready = 0, done_k = 0, ov_k = 0;
    send(2'd3, 48'd0, 32'd0, 32'd0, 24'd0);
    bus.req_type_i  = 2'd0;
    bus.req_sc_i    = 48'd2;
    bus.req_ns_i    = 32'd100;
    bus.req_valid_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (clear_rtc) begin
        clr_n++;
        if (k > 4) bad_ready++;
      end
      if (bus.req_ready_o !== (k == 5)) bad_ready++;
      if (done && done_k == 0) done_k = k;
      if (offset_valid && ov_k == 0) begin
        ov_k = k;
        checks++;
        if (ns_offset !== 32'd100 || sc_offset !== 48'd2) begin
          errors++; $display("FAIL held_step_vals: got %0d/%0d exp 100/2", ns_offset, sc_offset);
        end
      end
      if (k == 6) bus.req_valid_i = 1'b0;
    end
    checks++;
    if (clr_n !== 4 || done_k !== 5) begin errors++; $display("FAIL clear_len: got clr=%0d done@%0d exp 4 done@5", clr_n, done_k); end
    checks++;
    if (bad_ready !== 0 || ov_k !== 6) begin errors++; $display("FAIL clear_holdoff: got bad=%0d step@%0d exp 0 step@6", bad_ready, ov_k); end
    repeat (10) @(posedge clk);
  endtask

  task automatic test_slew_reset;
    int bad = 0, done_n = 0;
    send(2'd1, 48'd0, 32'd16, 32'd0, 24'd100);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (tick_inc !== 32'hF000_0010 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL slew_long_active: got %0d bad cycles exp 0", bad); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tick_inc !== TICK_DEF || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL slew_reset: got tick=%h busy=%b done=%b exp %h/0/0", tick_inc, busy, done, TICK_DEF);
    end
    rst_n = 1'b1;
    bad = 0;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (done) done_n++;
      if (tick_inc !== TICK_DEF) bad++;
    end
    checks++;
    if (done_n !== 0 || bad !== 0) begin errors++; $display("FAIL slew_reset_after: got done=%0d bad=%0d exp 0/0", done_n, bad); end
    send(2'd3, 48'd0, 32'd0, 32'd0, 24'd0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (clear_rtc !== 1'b1) begin errors++; $display("FAIL clr_before_reset: got %b exp 1", clear_rtc); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0; bad = 0;
    for (int k = 1; k <= 8; k++) begin
      if (clear_rtc) bad++;
      if (done) done_n++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0 || done_n !== 0) begin errors++; $display("FAIL clr_reset: got clr=%0d done=%0d exp 0/0", bad, done_n); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_step();
    test_step_err();
    test_setfreq_slew();
    test_back_to_back();
    test_slew_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptp_rtc_ctrl.md
PTP_RTC_CTRL -- requirements
Module: ptp_rtc_ctrl

Parameters
REQ-001 TICK_DEF, 32'h1999_999A, reset tick increment (6.4 ns in 6.26 unsigned format, 156.25 MHz).
REQ-002 GUARD_CYC, 8, idle cycles after each offset pulse before the next RTC command.
REQ-003 CLR_CYC, 4, number of cycles clear_rtc_o is held high.

Interface
REQ-004 rtc_clk  in  1  sole clock, all logic on the rising edge.
REQ-005 rtc_rst_n  in  1  reset, synchronous and active-low.
REQ-006 req_valid_i  in  1  command request valid.
REQ-007 req_ready_o  out  1  command accepted when high with req_valid_i.
REQ-008 req_type_i  in  2  command type: 0=STEP, 1=SLEW, 2=SETFREQ, 3=CLEAR.
REQ-009 req_sc_i  in  48  signed seconds offset (STEP).
REQ-010 req_ns_i  in  32  signed nanoseconds offset (STEP); signed tick delta (SLEW).
REQ-011 req_tick_i  in  32  new base tick increment (SETFREQ).
REQ-012 req_cyc_i  in  24  slew duration in cycles (SLEW).
REQ-013 tick_inc_o  out  32  tick increment driven to the RTC.
REQ-014 ns_offset_o  out  32  signed ns offset to the RTC.
REQ-015 sc_offset_o  out  48  signed seconds offset to the RTC.
REQ-016 offset_valid_o  out  1  one-cycle offset pulse to the RTC.
REQ-017 clear_rtc_o  out  1  RTC clear level.
REQ-018 busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-019 done_o  out  1  one-cycle pulse when a command completes.
REQ-020 err_o  out  1  one-cycle pulse when a command is rejected; rejection also counts as completion (no done_o).

Function
REQ-021 FSM states: IDLE, STEP, GUARD, SLEW, CLR.
REQ-022 req_ready_o is high only in IDLE; a command is accepted on the cycle req_valid_i and req_ready_o are both high, and all request fields are captured on that cycle.
REQ-023 STEP accepted with |req_ns_i| < 1_000_000_000:
- next cycle is the STEP state;
- in STEP: offset_valid_o=1, ns_offset_o=req_ns_i, sc_offset_o=req_sc_i;
- then GUARD for GUARD_CYC cycles;
- done_o on the last GUARD cycle, then IDLE.
REQ-024 STEP accepted with |req_ns_i| >= 1_000_000_000 (including -2^31): err_o pulses the next cycle, no offset_valid_o, returns to IDLE.
REQ-025 ns_offset_o and sc_offset_o hold their last driven values outside STEP; offset_valid_o is 0 outside STEP.
REQ-026 SETFREQ with req_tick_i != 0: base tick <= req_tick_i; tick_inc_o updates the next cycle; done_o pulses the same cycle; FSM stays IDLE.
REQ-027 SETFREQ with req_tick_i == 0: err_o pulses; base tick unchanged.
REQ-028 SLEW tick computation:
- slew tick = base tick + sign-extended req_ns_i, computed at 33 bits;
- if the result is <= 0 or >= 2^32, err_o pulses and the FSM stays IDLE;
- if req_cyc_i == 0, done_o pulses immediately and tick_inc_o is unchanged.
REQ-029 SLEW execution:
- tick_inc_o = slew tick for exactly req_cyc_i cycles, starting the cycle after acceptance;
- tick_inc_o returns to the base tick the following cycle, with done_o in that same cycle.
REQ-030 CLEAR: clear_rtc_o is high for exactly CLR_CYC consecutive cycles starting the cycle after acceptance; done_o pulses in the cycle clear_rtc_o falls; FSM returns to IDLE. The RTC's 2-stage synchronizer and edge detector need at least 3 high cycles.
REQ-031 Outside SLEW, tick_inc_o always equals the base tick.
REQ-032 Commands are never queued; req_valid_i while busy_o is high is ignored, not lost-and-errored.
REQ-033 done_o and err_o are mutually exclusive per command and never both high in one cycle.

Reset
REQ-034 When rtc_rst_n is low at a clock edge:
- FSM goes to IDLE and base tick is set to TICK_DEF;
- tick_inc_o=TICK_DEF, ns_offset_o=0, sc_offset_o=0;
- offset_valid_o, clear_rtc_o, done_o, err_o and busy_o are 0;
- req_ready_o is 1 from the first cycle after reset releases.
REQ-035 Reset asserted mid-SLEW, mid-GUARD or mid-CLR aborts the command immediately: no done_o, clear_rtc_o drops, tick_inc_o=TICK_DEF.

Verification
REQ-036 Reset then idle: tick_inc_o=32'h1999_999A, req_ready_o=1, all pulse outputs 0.
REQ-037 STEP with sc=-1, ns=500_000_000:
- one offset_valid_o pulse with sc_offset_o=48'hFFFF_FFFF_FFFF and ns_offset_o=500_000_000;
- busy_o high for 9 cycles;
- done_o pulse on the 9th cycle.
REQ-038 STEP with ns=1_000_000_000: err_o pulse, no offset_valid_o; a subsequent valid STEP is accepted normally.
REQ-039 SETFREQ to 32'h1900_0000, then SLEW with delta=+256 and cyc=3:
- tick_inc_o=32'h1900_0100 for exactly 3 cycles;
- then 32'h1900_0000 with done_o in that cycle.
REQ-040 CLEAR: clear_rtc_o high for exactly 4 cycles; a STEP presented throughout is held off (req_ready_o=0) until IDLE, then accepted.
REQ-041 SLEW with cyc=100 and reset asserted at cycle 50: tick_inc_o=TICK_DEF after the reset edge, no done_o.
